pong_renderer: RTL



---
 rtl/pong_renderer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pong_renderer.sv
// pong_renderer: VGA timing generator and sprite rasteriser for the pong board.
// Produces hsync/vsync and 12-bit RGB from the pixel clock, snapshots sprite
// positions once per frame during vertical blanking, and draws the square,
// both paddles and a dashed centre net with a two-cycle output pipeline.
// Build option: define PONG_BORDER_EN to add a 4-pixel white frame around
// the active area (same pipeline latency as the sprites).
module pong_renderer #(
    parameter int h_video       = 640,
    parameter int h_front       = 16,
    parameter int h_sync        = 96,
    parameter int h_back        = 48,
    parameter int v_video       = 480,
    parameter int v_front       = 10,
    parameter int v_sync        = 2,
    parameter int v_back        = 33,
    parameter int square_width  = 16,
    parameter int paddle_width  = 12,
    parameter int paddle_height = 96,
    parameter int net_width     = 4,
    parameter int net_dash      = 12
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic [9:0] square_xpos,
    input  logic [9:0] square_ypos,
    input  logic [9:0] paddle1_xpos,
    input  logic [9:0] paddle1_ypos,
    input  logic [9:0] paddle2_xpos,
    input  logic [9:0] paddle2_ypos,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       frame_tick,
    output logic       video_on
);

    localparam int h_total  = h_video + h_front + h_sync + h_back;
    localparam int v_total  = v_video + v_front + v_sync + v_back;
    localparam int net_left = h_video / 2 - net_width / 2;
    localparam int dash_w   = (net_dash > 1) ? $clog2(net_dash) : 1;

    localparam logic [9:0]  h_last      = 10'(h_total - 1);
    localparam logic [9:0]  v_last      = 10'(v_total - 1);
    localparam logic [9:0]  h_sync_beg  = 10'(h_video + h_front);
    localparam logic [9:0]  h_sync_end  = 10'(h_video + h_front + h_sync);
    localparam logic [9:0]  v_sync_beg  = 10'(v_video + v_front);
    localparam logic [9:0]  v_sync_end  = 10'(v_video + v_front + v_sync);
    localparam logic [9:0]  h_vid_lim   = 10'(h_video);
    localparam logic [9:0]  v_vid_lim   = 10'(v_video);
    localparam logic [10:0] net_lo      = 11'(net_left);
    localparam logic [10:0] net_hi      = 11'(net_left + net_width);
    localparam logic [dash_w-1:0] dash_last = dash_w'(net_dash - 1);

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       line_end;
    logic       latch;

    logic [9:0] sq_x, sq_y, p1_x, p1_y, p2_x, p2_y;

    logic [dash_w-1:0] dash_count;
    logic              dash_on;

    logic s1_square, s1_paddle1, s1_paddle2, s1_net;
    logic s1_active, s1_hsync, s1_vsync;
    logic any_hit;

`ifdef PONG_BORDER_EN
    localparam int border_px = 4;
    localparam logic [9:0] h_border_hi = 10'(h_video - border_px);
    localparam logic [9:0] v_border_hi = 10'(v_video - border_px);
    localparam logic [9:0] border_lim  = 10'(border_px);
    logic s1_border;
`endif

    // Sums are formed in 11 bits so an object near the right/bottom edge
    // never wraps back onto column/line 0.
    function automatic logic in_box(input logic [9:0] hc, input logic [9:0] vc,
                                    input logic [9:0] px, input logic [9:0] py,
                                    input int w, input int h);
        logic [10:0] hx, vy, x0, y0;
        hx = {1'b0, hc};
        vy = {1'b0, vc};
        x0 = {1'b0, px};
        y0 = {1'b0, py};
        return (hx >= x0) && (hx < x0 + 11'(w)) && (vy >= y0) && (vy < y0 + 11'(h));
    endfunction

    assign line_end   = (h_count == h_last);
    assign latch      = (h_count == 10'd0) && (v_count == v_vid_lim);
    assign frame_tick = latch;

    // Raster counters: h wraps every line, v advances on each h wrap.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            h_count <= '0;
            v_count <= '0;
        end else if (line_end) begin
            h_count <= '0;
            v_count <= (v_count == v_last) ? 10'd0 : v_count + 10'd1;
        end else begin
            h_count <= h_count + 10'd1;
        end
    end

    // Shadow positions, refreshed only at the start of vertical blanking.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            sq_x <= 10'd320;
            sq_y <= 10'd240;
            p1_x <= 10'd24;
            p1_y <= 10'd191;
            p2_x <= 10'd603;
            p2_y <= 10'd191;
        end else if (latch) begin
            sq_x <= square_xpos;
            sq_y <= square_ypos;
            p1_x <= paddle1_xpos;
            p1_y <= paddle1_ypos;
            p2_x <= paddle2_xpos;
            p2_y <= paddle2_ypos;
        end
    end

    // Net dash phase: steps once per line, restarts "on" for line 0.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            dash_count <= '0;
            dash_on    <= 1'b1;
        end else if (line_end) begin
            if (v_count == v_last) begin
                dash_count <= '0;
                dash_on    <= 1'b1;
            end else if (dash_count == dash_last) begin
                dash_count <= '0;
                dash_on    <= ~dash_on;
            end else begin
                dash_count <= dash_count + 1'b1;
            end
        end
    end

    // Stage 1: hit flags plus raw active/sync derived from the counters.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            s1_square  <= 1'b0;
            s1_paddle1 <= 1'b0;
            s1_paddle2 <= 1'b0;
            s1_net     <= 1'b0;
            s1_active  <= 1'b0;
            s1_hsync   <= 1'b1;
            s1_vsync   <= 1'b1;
        end else begin
            s1_square  <= in_box(h_count, v_count, sq_x, sq_y, square_width, square_width);
            s1_paddle1 <= in_box(h_count, v_count, p1_x, p1_y, paddle_width, paddle_height);
            s1_paddle2 <= in_box(h_count, v_count, p2_x, p2_y, paddle_width, paddle_height);
            s1_net     <= dash_on && ({1'b0, h_count} >= net_lo) && ({1'b0, h_count} < net_hi);
            s1_active  <= (h_count < h_vid_lim) && (v_count < v_vid_lim);
            s1_hsync   <= !((h_count >= h_sync_beg) && (h_count < h_sync_end));
            s1_vsync   <= !((v_count >= v_sync_beg) && (v_count < v_sync_end));
        end
    end

`ifdef PONG_BORDER_EN
    // Stage 1 border flag, kept in step with the sprite hit flags.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            s1_border <= 1'b0;
        end else begin
            s1_border <= (h_count < border_lim) || (h_count >= h_border_hi) ||
                         (v_count < border_lim) || (v_count >= v_border_hi);
        end
    end
    assign any_hit = s1_square | s1_paddle1 | s1_paddle2 | s1_net | s1_border;
`else
    assign any_hit = s1_square | s1_paddle1 | s1_paddle2 | s1_net;
`endif

    // Stage 2: colour and sync registered together so they stay aligned.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            red      <= 4'h0;
            green    <= 4'h0;
            blue     <= 4'h0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
        end else begin
            red      <= {4{s1_active & any_hit}};
            green    <= {4{s1_active & any_hit}};
            blue     <= {4{s1_active & any_hit}};
            hsync    <= s1_hsync;
            vsync    <= s1_vsync;
            video_on <= s1_active;
        end
    end

endmodule
